// File: rtl/decode_stage.sv
// decode_stage: 2-entry fetch FIFO feeding a combinational Decoder into a
// registered uop slot. Define DECODE_STAGE_PERF_EN for perfIssued/perfStall.
package Instr;

   typedef logic [31:0] enc_t;

   localparam logic [6:0] OP_ARITH = 7'b0110011;
   localparam logic [6:0] OP_IMM   = 7'b0010011;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_LD    = 7'b0000011;
   localparam logic [6:0] OP_ST    = 7'b0100011;

endpackage

package Uop;

   typedef enum logic [1:0] {
      FU_NONE   = 2'd0,
      FU_INTALU = 2'd1,
      FU_MEM    = 2'd2
   } fu_t;

   typedef enum logic [3:0] {
      INTALU_OP_ADD  = 4'd0,
      INTALU_OP_SUB  = 4'd1,
      INTALU_OP_SLL  = 4'd2,
      INTALU_OP_SLT  = 4'd3,
      INTALU_OP_SLTU = 4'd4,
      INTALU_OP_XOR  = 4'd5,
      INTALU_OP_SRL  = 4'd6,
      INTALU_OP_SRA  = 4'd7,
      INTALU_OP_OR   = 4'd8,
      INTALU_OP_AND  = 4'd9,
      INTALU_OP_LUI  = 4'd10
   } intalu_op_t;

   typedef enum logic [1:0] {
      MEM_OP_SZ_B = 2'd0,
      MEM_OP_SZ_H = 2'd1,
      MEM_OP_SZ_W = 2'd2
   } mem_op_sz_t;

   typedef struct packed {
      logic       isLd;
      logic       isSt;
      logic       isUns;
      mem_op_sz_t sz;
   } mem_op_t;

   typedef struct packed {
      intalu_op_t intalu;
   } op_t;

   typedef struct packed {
      fu_t         fu;
      op_t         op;
      mem_op_t     memOp;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic        useImm;
      logic [31:0] imm;
      logic        exValid;
   } dec_t;

endpackage

module Decoder
   import Instr::*;
   import Uop::*;
(
   input  enc_t i_enc,
   output dec_t o_dec
);

   logic [6:0]  w_opc;
   logic [2:0]  w_f3;
   logic [6:0]  w_f7;
   logic [31:0] w_immI;
   logic [31:0] w_immS;
   logic        w_ill;

   assign w_opc  = i_enc[6:0];
   assign w_f3   = i_enc[14:12];
   assign w_f7   = i_enc[31:25];
   assign w_immI = {{20{i_enc[31]}}, i_enc[31:20]};
   assign w_immS = {{20{i_enc[31]}}, i_enc[31:25], i_enc[11:7]};

   always_comb begin
      o_dec = '0;
      w_ill = 1'b0;
      case (w_opc)
         OP_ARITH: begin
            o_dec.fu  = FU_INTALU;
            o_dec.rd  = i_enc[11:7];
            o_dec.rs1 = i_enc[19:15];
            o_dec.rs2 = i_enc[24:20];
            if (w_f7 == 7'h00) begin
               case (w_f3)
                  3'd0:    o_dec.op.intalu = INTALU_OP_ADD;
                  3'd1:    o_dec.op.intalu = INTALU_OP_SLL;
                  3'd2:    o_dec.op.intalu = INTALU_OP_SLT;
                  3'd3:    o_dec.op.intalu = INTALU_OP_SLTU;
                  3'd4:    o_dec.op.intalu = INTALU_OP_XOR;
                  3'd5:    o_dec.op.intalu = INTALU_OP_SRL;
                  3'd6:    o_dec.op.intalu = INTALU_OP_OR;
                  default: o_dec.op.intalu = INTALU_OP_AND;
               endcase
            end else if (w_f7 == 7'h20) begin
               case (w_f3)
                  3'd0:    o_dec.op.intalu = INTALU_OP_SUB;
                  3'd5:    o_dec.op.intalu = INTALU_OP_SRA;
                  default: w_ill = 1'b1;
               endcase
            end else begin
               w_ill = 1'b1;
            end
         end
         OP_IMM: begin
            o_dec.fu     = FU_INTALU;
            o_dec.rd     = i_enc[11:7];
            o_dec.rs1    = i_enc[19:15];
            o_dec.useImm = 1'b1;
            o_dec.imm    = w_immI;
            case (w_f3)
               3'd0: o_dec.op.intalu = INTALU_OP_ADD;
               3'd2: o_dec.op.intalu = INTALU_OP_SLT;
               3'd3: o_dec.op.intalu = INTALU_OP_SLTU;
               3'd4: o_dec.op.intalu = INTALU_OP_XOR;
               3'd6: o_dec.op.intalu = INTALU_OP_OR;
               3'd7: o_dec.op.intalu = INTALU_OP_AND;
               3'd1: begin
                  o_dec.op.intalu = INTALU_OP_SLL;
                  w_ill = (w_f7 != 7'h00);
               end
               default: begin
                  if (w_f7 == 7'h00)
                     o_dec.op.intalu = INTALU_OP_SRL;
                  else if (w_f7 == 7'h20)
                     o_dec.op.intalu = INTALU_OP_SRA;
                  else
                     w_ill = 1'b1;
               end
            endcase
         end
         OP_LUI: begin
            o_dec.fu        = FU_INTALU;
            o_dec.op.intalu = INTALU_OP_LUI;
            o_dec.rd        = i_enc[11:7];
            o_dec.useImm    = 1'b1;
            o_dec.imm       = {i_enc[31:12], 12'h000};
         end
         OP_LD: begin
            o_dec.fu         = FU_MEM;
            o_dec.memOp.isLd = 1'b1;
            o_dec.rd         = i_enc[11:7];
            o_dec.rs1        = i_enc[19:15];
            o_dec.useImm     = 1'b1;
            o_dec.imm        = w_immI;
            o_dec.memOp.isUns = w_f3[2];
            case (w_f3)
               3'd0, 3'd4: o_dec.memOp.sz = MEM_OP_SZ_B;
               3'd1, 3'd5: o_dec.memOp.sz = MEM_OP_SZ_H;
               3'd2:       o_dec.memOp.sz = MEM_OP_SZ_W;
               default:    w_ill = 1'b1;
            endcase
         end
         OP_ST: begin
            o_dec.fu         = FU_MEM;
            o_dec.memOp.isSt = 1'b1;
            o_dec.rs1        = i_enc[19:15];
            o_dec.rs2        = i_enc[24:20];
            o_dec.useImm     = 1'b1;
            o_dec.imm        = w_immS;
            case (w_f3)
               3'd0:    o_dec.memOp.sz = MEM_OP_SZ_B;
               3'd1:    o_dec.memOp.sz = MEM_OP_SZ_H;
               3'd2:    o_dec.memOp.sz = MEM_OP_SZ_W;
               default: w_ill = 1'b1;
            endcase
         end
         default: w_ill = 1'b1;
      endcase
      // An illegal encoding carries only the exception flag downstream.
      if (w_ill) begin
         o_dec         = '0;
         o_dec.exValid = 1'b1;
      end
   end

endmodule

module decode_stage
   import Instr::*;
   import Uop::*;
#(
   parameter int PC_W = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            inValid,
   output logic            inReady,
   input  enc_t            inEnc,
   input  logic [PC_W-1:0] inPc,
   output logic            outValid,
   input  logic            outReady,
   output dec_t            outDec,
   output logic [PC_W-1:0] outPc,
   input  logic            flush,
   output logic            halted
`ifdef DECODE_STAGE_PERF_EN
   ,
   output logic [31:0]     perfIssued,
   output logic [31:0]     perfStall
`endif
);

   localparam logic ST_RUN  = 1'b0;
   localparam logic ST_HALT = 1'b1;

   enc_t            r_enc [2];
   logic [PC_W-1:0] r_pc  [2];
   logic            r_head;
   logic [1:0]      r_count;
   logic            r_state;
   logic            r_outValid;
   dec_t            r_outDec;
   logic [PC_W-1:0] r_outPc;

   logic            w_tail;
   logic            w_run;
   logic            w_push;
   logic            w_load;
   dec_t            w_dec;

   assign w_tail  = r_head ^ r_count[0];
   assign w_run   = (r_state == ST_RUN);
   assign inReady = !rst && !flush && w_run && (r_count != 2'd2);
   assign w_push  = inValid && inReady;
   assign w_load  = !rst && !flush && w_run && (r_count != 2'd0)
                    && (!r_outValid || outReady);

   Decoder u_dec (
      .i_enc (r_enc[r_head]),
      .o_dec (w_dec)
   );

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_enc[w_tail] <= inEnc;
         r_pc[w_tail]  <= inPc;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_count    <= 2'd0;
         r_head     <= 1'b0;
         r_state    <= ST_RUN;
         r_outValid <= 1'b0;
         r_outDec   <= '0;
         r_outPc    <= '0;
      end else if (flush) begin
         r_count    <= 2'd0;
         r_head     <= 1'b0;
         r_state    <= ST_RUN;
         r_outValid <= 1'b0;
      end else begin
         if (w_load) begin
            r_outValid <= 1'b1;
            r_outDec   <= w_dec;
            r_outPc    <= r_pc[r_head];
            r_head     <= ~r_head;
            // The excepting uop still issues; younger ones wait for flush.
            if (w_dec.exValid)
               r_state <= ST_HALT;
         end else if (outReady) begin
            r_outValid <= 1'b0;
         end
         unique case (1'b1)
            w_push && !w_load: r_count <= r_count + 2'd1;
            !w_push && w_load: r_count <= r_count - 2'd1;
            default: ;
         endcase
      end
   end

   assign outValid = r_outValid;
   assign outDec   = r_outDec;
   assign outPc    = r_outPc;
   assign halted   = (r_state == ST_HALT);

`ifdef DECODE_STAGE_PERF_EN
   logic [31:0] r_perfIssued;
   logic [31:0] r_perfStall;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_perfIssued <= '0;
         r_perfStall  <= '0;
      end else begin
         if (r_outValid && outReady)
            r_perfIssued <= r_perfIssued + 32'd1;
         if (r_outValid && !outReady)
            r_perfStall <= r_perfStall + 32'd1;
      end
   end

   assign perfIssued = r_perfIssued;
   assign perfStall  = r_perfStall;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboarded bench for decode_stage: reset, streaming, backpressure,
// exception halt, flush collision, perf counters when enabled.
module tb_decode_stage;
   import Instr::*;
   import Uop::*;

   typedef struct {
      dec_t        dec;
      logic [31:0] pc;
   } sb_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        inValid;
   logic        inReady;
   enc_t        inEnc;
   logic [31:0] inPc;
   logic        outValid;
   logic        outReady;
   dec_t        outDec;
   logic [31:0] outPc;
   logic        flush;
   logic        halted;
`ifdef DECODE_STAGE_PERF_EN
   logic [31:0] perfIssued;
   logic [31:0] perfStall;
`endif

   dec_t exp_dec;
   sb_t  sb_q[$];
   sb_t  mon_e;
   int   n_chk = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   decode_stage #(.PC_W(32)) dut (
      .clk      (clk),
      .rst      (rst),
      .inValid  (inValid),
      .inReady  (inReady),
      .inEnc    (inEnc),
      .inPc     (inPc),
      .outValid (outValid),
      .outReady (outReady),
      .outDec   (outDec),
      .outPc    (outPc),
      .flush    (flush),
      .halted   (halted)
`ifdef DECODE_STAGE_PERF_EN
      ,
      .perfIssued (perfIssued),
      .perfStall  (perfStall)
`endif
   );

   function automatic enc_t enc_add(input logic [4:0] rd);
      return {7'd0, 5'd2, 5'd1, 3'd0, rd, 7'b0110011};
   endfunction

   function automatic dec_t exp_add(input logic [4:0] rd);
      dec_t d = '0;
      d.fu        = FU_INTALU;
      d.op.intalu = INTALU_OP_ADD;
      d.rd        = rd;
      return d;
   endfunction

   function automatic enc_t enc_ld_bad();
      return {12'h010, 5'd1, 3'b011, 5'd5, 7'b0000011};
   endfunction

   function automatic dec_t exp_ex();
      dec_t d = '0;
      d.exValid = 1'b1;
      return d;
   endfunction

   function automatic enc_t enc_sw();
      return {7'd0, 5'd3, 5'd1, 3'b010, 5'd8, 7'b0100011};
   endfunction

   function automatic dec_t exp_sw();
      dec_t d = '0;
      d.fu         = FU_MEM;
      d.memOp.isSt = 1'b1;
      d.memOp.sz   = MEM_OP_SZ_W;
      return d;
   endfunction

   // Scoreboard: push on accept, pop and compare on output handshake.
   always @(negedge clk) begin
      if (rst) begin
         sb_q.delete();
      end else begin
         if (inValid && inReady)
            sb_q.push_back('{dec: exp_dec, pc: inPc});
         if (outValid && outReady) begin
            n_chk++;
            if (sb_q.size() == 0) begin
               n_fail++;
               $display("FAIL uop_unexpected: got pc %h, required no uop", outPc);
            end else begin
               mon_e = sb_q.pop_front();
               if (outDec.fu !== mon_e.dec.fu
                   || outDec.op.intalu !== mon_e.dec.op.intalu
                   || outDec.memOp !== mon_e.dec.memOp
                   || outDec.rd !== mon_e.dec.rd
                   || outDec.exValid !== mon_e.dec.exValid
                   || outPc !== mon_e.pc) begin
                  n_fail++;
                  $display("FAIL uop_data: got fu=%0d op=%0d mem=%b rd=%0d ex=%b pc=%h, required fu=%0d op=%0d mem=%b rd=%0d ex=%b pc=%h",
                           outDec.fu, outDec.op.intalu, outDec.memOp, outDec.rd,
                           outDec.exValid, outPc, mon_e.dec.fu,
                           mon_e.dec.op.intalu, mon_e.dec.memOp, mon_e.dec.rd,
                           mon_e.dec.exValid, mon_e.pc);
               end
            end
         end
         if (flush)
            sb_q.delete();
      end
   end

   task automatic drive(input logic v, input enc_t e,
                        input logic [31:0] pc, input dec_t d);
      inValid = v;
      inEnc   = e;
      inPc    = pc;
      exp_dec = d;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (sb_q.size() == 0 && !outValid) begin
            ok = 1'b1;
            break;
         end
      end
      step();
   endtask

   task automatic test_reset();
      bit ok;
      rst      = 1'b1;
      flush    = 1'b0;
      outReady = 1'b0;
      drive(1'b1, enc_add(5'd9), 32'h100, exp_add(5'd9));
      step();
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         n_chk++;
         if (inReady !== 1'b0 || outValid !== 1'b0 || halted !== 1'b0
             || outDec !== dec_t'('0) || outPc !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_state: inReady=%b outValid=%b halted=%b pc=%h, required 0 0 0 0",
                     inReady, outValid, halted, outPc);
         end
         step();
      end
      rst = 1'b0;
      @(negedge clk);
      n_chk++;
      if (inReady !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_release: inReady=%b, required 1", inReady);
      end
      step();
      drive(1'b0, '0, '0, '0);
      outReady = 1'b1;
      wait_idle(ok);
      n_chk++;
      if (!ok) begin
         n_fail++;
         $display("FAIL reset_drain: queue=%0d, required 0", sb_q.size());
      end
   endtask

   task automatic test_streaming();
      int n_acc = 0;
      int n_ov = 0;
      int first_ov = -1;
      int last_ov = -1;
      outReady = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (i < 4)
            drive(1'b1, enc_add(5'(i + 1)), 32'(i * 4), exp_add(5'(i + 1)));
         else
            drive(1'b0, '0, '0, '0);
         @(negedge clk);
         if (inValid && inReady)
            n_acc++;
         if (outValid) begin
            if (first_ov < 0)
               first_ov = i;
            last_ov = i;
            n_ov++;
         end
         step();
      end
      n_chk++;
      if (n_acc != 4) begin
         n_fail++;
         $display("FAIL stream_accepts: got %0d, required 4", n_acc);
      end
      n_chk++;
      if (first_ov != 2) begin
         n_fail++;
         $display("FAIL stream_latency: first outValid at %0d, required 2", first_ov);
      end
      n_chk++;
      if (n_ov != 4 || last_ov != 5) begin
         n_fail++;
         $display("FAIL stream_throughput: %0d uops ending %0d, required 4 ending 5",
                  n_ov, last_ov);
      end
   endtask

   task automatic test_backpressure();
      int  n_acc = 0;
      int  idx = 0;
      int  n_hs = 0;
      bit  acc;
      bit  ok;
      outReady = 1'b0;
      drive(1'b1, enc_add(5'd10), 32'h40, exp_add(5'd10));
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         acc = inValid && inReady;
         if (outValid) begin
            n_chk++;
            if (outDec.rd !== 5'd10 || outPc !== 32'h40) begin
               n_fail++;
               $display("FAIL bp_hold: rd=%0d pc=%h, required 10 00000040",
                        outDec.rd, outPc);
            end
         end
         step();
         if (acc) begin
            n_acc++;
            idx++;
            if (idx < 5)
               drive(1'b1, enc_add(5'(10 + idx)), 32'h40 + 32'(4 * idx),
                     exp_add(5'(10 + idx)));
            else
               drive(1'b0, '0, '0, '0);
         end
      end
      n_chk++;
      if (n_acc != 3) begin
         n_fail++;
         $display("FAIL bp_accepts: got %0d, required 3", n_acc);
      end
      @(negedge clk);
      n_chk++;
      if (inReady !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_full: inReady=%b, required 0", inReady);
      end
      step();
      drive(1'b0, '0, '0, '0);
      outReady = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (outValid && outReady)
            n_hs++;
         step();
      end
      n_chk++;
      if (n_hs != 3) begin
         n_fail++;
         $display("FAIL bp_drain: got %0d uops, required 3", n_hs);
      end
      wait_idle(ok);
   endtask

   task automatic test_exception();
      int first_ov = -1;
      outReady = 1'b1;
      drive(1'b1, enc_ld_bad(), 32'h80, exp_ex());
      step();
      drive(1'b1, enc_sw(), 32'h84, exp_sw());
      step();
      drive(1'b0, '0, '0, '0);
      @(negedge clk);
      n_chk++;
      if (outValid !== 1'b1 || outDec.exValid !== 1'b1 || halted !== 1'b1) begin
         n_fail++;
         $display("FAIL ex_issue: outValid=%b exValid=%b halted=%b, required 1 1 1",
                  outValid, outDec.exValid, halted);
      end
      step();
      drive(1'b1, enc_add(5'd7), 32'h88, exp_add(5'd7));
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_chk++;
         if (outValid !== 1'b0 || halted !== 1'b1 || inReady !== 1'b0) begin
            n_fail++;
            $display("FAIL ex_halt: outValid=%b halted=%b inReady=%b, required 0 1 0",
                     outValid, halted, inReady);
         end
         step();
      end
      drive(1'b0, '0, '0, '0);
      flush = 1'b1;
      step();
      flush = 1'b0;
      @(negedge clk);
      n_chk++;
      if (halted !== 1'b0 || outValid !== 1'b0 || inReady !== 1'b1) begin
         n_fail++;
         $display("FAIL ex_flush: halted=%b outValid=%b inReady=%b, required 0 0 1",
                  halted, outValid, inReady);
      end
      step();
      for (int i = 0; i < 5; i++) begin
         if (i == 0)
            drive(1'b1, enc_sw(), 32'h90, exp_sw());
         else
            drive(1'b0, '0, '0, '0);
         @(negedge clk);
         if (outValid && first_ov < 0) begin
            first_ov = i;
            n_chk++;
            if (outDec.memOp.isSt !== 1'b1 || outDec.memOp.sz !== MEM_OP_SZ_W
                || outPc !== 32'h90) begin
               n_fail++;
               $display("FAIL ex_newst: isSt=%b sz=%0d pc=%h, required 1 2 00000090",
                        outDec.memOp.isSt, outDec.memOp.sz, outPc);
            end
         end
         step();
      end
      n_chk++;
      if (first_ov != 2) begin
         n_fail++;
         $display("FAIL ex_newst_latency: at %0d, required 2", first_ov);
      end
   endtask

   task automatic test_flush_collision();
      int n_acc = 0;
      int idx = 0;
      bit acc;
      outReady = 1'b0;
      drive(1'b1, enc_add(5'd16), 32'hA0, exp_add(5'd16));
      for (int i = 0; i < 10 && n_acc < 3; i++) begin
         @(negedge clk);
         acc = inValid && inReady;
         step();
         if (acc) begin
            n_acc++;
            idx++;
            drive(1'b1, enc_add(5'(16 + idx)), 32'hA0 + 32'(4 * idx),
                  exp_add(5'(16 + idx)));
         end
      end
      n_chk++;
      if (n_acc != 3) begin
         n_fail++;
         $display("FAIL fc_fill: got %0d accepts, required 3", n_acc);
      end
      drive(1'b1, enc_add(5'd20), 32'hC0, exp_add(5'd20));
      flush = 1'b1;
      @(negedge clk);
      n_chk++;
      if (inReady !== 1'b0) begin
         n_fail++;
         $display("FAIL fc_collide: inReady=%b, required 0", inReady);
      end
      step();
      flush = 1'b0;
      drive(1'b0, '0, '0, '0);
      @(negedge clk);
      n_chk++;
      if (outValid !== 1'b0 || inReady !== 1'b1) begin
         n_fail++;
         $display("FAIL fc_after: outValid=%b inReady=%b, required 0 1",
                  outValid, inReady);
      end
      step();
      outReady = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_chk++;
         if (outValid !== 1'b0) begin
            n_fail++;
            $display("FAIL fc_empty: outValid=%b pc=%h, required 0", outValid, outPc);
         end
         step();
      end
   endtask

`ifdef DECODE_STAGE_PERF_EN
   task automatic test_perf();
      int n_st = 0;
      int n_hs = 0;
      int idx = 0;
      bit acc;
      rst = 1'b1;
      outReady = 1'b0;
      drive(1'b0, '0, '0, '0);
      step();
      rst = 1'b0;
      @(negedge clk);
      n_chk++;
      if (perfIssued !== 32'd0 || perfStall !== 32'd0) begin
         n_fail++;
         $display("FAIL perf_reset: issued=%0d stall=%0d, required 0 0",
                  perfIssued, perfStall);
      end
      step();
      drive(1'b1, enc_add(5'd24), 32'hE0, exp_add(5'd24));
      for (int i = 0; i < 30 && n_hs < 3; i++) begin
         @(negedge clk);
         acc = inValid && inReady;
         if (outValid && !outReady)
            n_st++;
         if (outValid && outReady)
            n_hs++;
         step();
         if (acc) begin
            idx++;
            if (idx < 3)
               drive(1'b1, enc_add(5'(24 + idx)), 32'hE0 + 32'(4 * idx),
                     exp_add(5'(24 + idx)));
            else
               drive(1'b0, '0, '0, '0);
         end
         if (n_st >= 5)
            outReady = 1'b1;
      end
      @(negedge clk);
      n_chk++;
      if (perfIssued !== 32'd3 || perfStall !== 32'd5) begin
         n_fail++;
         $display("FAIL perf_count: issued=%0d stall=%0d, required 3 5",
                  perfIssued, perfStall);
      end
      step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      @(negedge clk);
      n_chk++;
      if (perfIssued !== 32'd3 || perfStall !== 32'd5) begin
         n_fail++;
         $display("FAIL perf_flush: issued=%0d stall=%0d, required 3 5",
                  perfIssued, perfStall);
      end
      step();
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_streaming();
      test_backpressure();
      test_exception();
      test_flush_collision();
`ifdef DECODE_STAGE_PERF_EN
      test_perf();
`endif
      n_chk++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL sb_leftover: %0d pending, required 0", sb_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
